// File: rtl/avalon_bus_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with atomic burst ownership.
// Read data is broadcast; the valid strobe goes only to the burst owner.
module avalon_bus_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteEnable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writeData,
    input  logic                  m0_beginBurstTransfer,
    input  logic [7:0]            m0_burstCount,
    output logic [DATA_W-1:0]     m0_readData,
    output logic                  m0_readDataValid,
    output logic                  m0_waitRequest,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteEnable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writeData,
    input  logic                  m1_beginBurstTransfer,
    input  logic [7:0]            m1_burstCount,
    output logic [DATA_W-1:0]     m1_readData,
    output logic                  m1_readDataValid,
    output logic                  m1_waitRequest,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W/8-1:0]   s_byteEnable,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writeData,
    output logic                  s_beginBurstTransfer,
    output logic [7:0]            s_burstCount,
    input  logic [DATA_W-1:0]     s_readData,
    input  logic                  s_readDataValid,
    input  logic                  s_waitRequest
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_DATA} stateT;

    stateT      state, stateNext;
    logic       grant, grantNext;
    logic       lastGrant, lastGrantNext;
    logic [7:0] count, countNext;

    logic [1:0] req;
    logic       winner;
    logic       wWrite;
    logic [7:0] wBurst;
    logic       gRead;
    logic       gWrite;
    logic [7:0] gBurst;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    // On contention the master that did not own the bus last goes next.
    always_comb begin
        if (req == 2'b11) winner = (ROUND_ROBIN != 0) ? ~lastGrant : 1'b0;
        else              winner = req[1];
    end

    assign wWrite = winner ? m1_write : m0_write;
    assign wBurst = winner ? m1_burstCount : m0_burstCount;
    assign gRead  = grant ? m1_read : m0_read;
    assign gWrite = grant ? m1_write : m0_write;
    assign gBurst = grant ? m1_burstCount : m0_burstCount;

    assign m0_readData = s_readData;
    assign m1_readData = s_readData;

    always_comb begin
        stateNext            = state;
        grantNext            = grant;
        lastGrantNext        = lastGrant;
        countNext            = count;
        s_address            = '0;
        s_byteEnable         = '0;
        s_read               = 1'b0;
        s_write              = 1'b0;
        s_writeData          = '0;
        s_beginBurstTransfer = 1'b0;
        s_burstCount         = '0;
        m0_waitRequest       = 1'b1;
        m1_waitRequest       = 1'b1;
        m0_readDataValid     = 1'b0;
        m1_readDataValid     = 1'b0;

        if (state == WRITE || state == READ_CMD) begin
            s_address            = grant ? m1_address : m0_address;
            s_byteEnable         = grant ? m1_byteEnable : m0_byteEnable;
            s_writeData          = grant ? m1_writeData : m0_writeData;
            s_beginBurstTransfer = grant ? m1_beginBurstTransfer
                                         : m0_beginBurstTransfer;
            s_burstCount         = gBurst;
            s_read               = gRead;
            s_write              = gWrite;
            if (grant) m1_waitRequest = s_waitRequest;
            else       m0_waitRequest = s_waitRequest;
        end

        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grantNext = winner;
                    if (wWrite) begin
                        stateNext = WRITE;
                        countNext = (wBurst == 8'd0) ? 8'd1 : wBurst;
                    end else begin
                        stateNext = READ_CMD;
                    end
                end
            end
            WRITE: begin
                if (gWrite && !s_waitRequest && count != 8'd0) begin
                    countNext = count - 8'd1;
                    if (count == 8'd1) begin
                        stateNext     = IDLE;
                        lastGrantNext = grant;
                    end
                end
            end
            READ_CMD: begin
                if (gRead && !s_waitRequest) begin
                    stateNext = READ_DATA;
                    countNext = (gBurst == 8'd0) ? 8'd1 : gBurst;
                end
            end
            READ_DATA: begin
                if (s_readDataValid) begin
                    if (grant) m1_readDataValid = 1'b1;
                    else       m0_readDataValid = 1'b1;
                    if (count != 8'd0) begin
                        countNext = count - 8'd1;
                        if (count == 8'd1) begin
                            stateNext     = IDLE;
                            lastGrantNext = grant;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 1'b0;
            lastGrant <= 1'b1;
            count     <= 8'd0;
        end else begin
            state     <= stateNext;
            grant     <= grantNext;
            lastGrant <= lastGrantNext;
            count     <= countNext;
        end
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: cycle vector table plus
// hand-written burst, reset and priority sequences.
module tb_avalon_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_address, m1_address;
    logic [3:0]  m0_byteEnable, m1_byteEnable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writeData, m1_writeData;
    logic        m0_beginBurstTransfer, m1_beginBurstTransfer;
    logic [7:0]  m0_burstCount, m1_burstCount;
    logic [31:0] m0_readData, m1_readData;
    logic        m0_readDataValid, m1_readDataValid;
    logic        m0_waitRequest, m1_waitRequest;
    logic [31:0] s_address;
    logic [3:0]  s_byteEnable;
    logic        s_read, s_write;
    logic [31:0] s_writeData;
    logic        s_beginBurstTransfer;
    logic [7:0]  s_burstCount;
    logic [31:0] s_readData;
    logic        s_readDataValid, s_waitRequest;

    logic [31:0] f_m0ReadData, f_m1ReadData;
    logic        f_m0Rdv, f_m1Rdv, f_m0Wait, f_m1Wait;
    logic [31:0] f_sAddress;
    logic [3:0]  f_sByteEnable;
    logic        f_sRead, f_sWrite;
    logic [31:0] f_sWriteData;
    logic        f_sBegin;
    logic [7:0]  f_sBurst;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ROUND_ROBIN(1), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_byteEnable(m0_byteEnable),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_writeData(m0_writeData),
        .m0_beginBurstTransfer(m0_beginBurstTransfer),
        .m0_burstCount(m0_burstCount), .m0_readData(m0_readData),
        .m0_readDataValid(m0_readDataValid),
        .m0_waitRequest(m0_waitRequest),
        .m1_address(m1_address), .m1_byteEnable(m1_byteEnable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_writeData(m1_writeData),
        .m1_beginBurstTransfer(m1_beginBurstTransfer),
        .m1_burstCount(m1_burstCount), .m1_readData(m1_readData),
        .m1_readDataValid(m1_readDataValid),
        .m1_waitRequest(m1_waitRequest),
        .s_address(s_address), .s_byteEnable(s_byteEnable),
        .s_read(s_read), .s_write(s_write), .s_writeData(s_writeData),
        .s_beginBurstTransfer(s_beginBurstTransfer),
        .s_burstCount(s_burstCount), .s_readData(s_readData),
        .s_readDataValid(s_readDataValid), .s_waitRequest(s_waitRequest)
    );

    avalon_bus_arbiter #(.ROUND_ROBIN(0), .DATA_W(32), .ADDR_W(32)) dutFixed (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_byteEnable(m0_byteEnable),
        .m0_read(m0_read), .m0_write(m0_write),
        .m0_writeData(m0_writeData),
        .m0_beginBurstTransfer(m0_beginBurstTransfer),
        .m0_burstCount(m0_burstCount), .m0_readData(f_m0ReadData),
        .m0_readDataValid(f_m0Rdv), .m0_waitRequest(f_m0Wait),
        .m1_address(m1_address), .m1_byteEnable(m1_byteEnable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_writeData(m1_writeData),
        .m1_beginBurstTransfer(m1_beginBurstTransfer),
        .m1_burstCount(m1_burstCount), .m1_readData(f_m1ReadData),
        .m1_readDataValid(f_m1Rdv), .m1_waitRequest(f_m1Wait),
        .s_address(f_sAddress), .s_byteEnable(f_sByteEnable),
        .s_read(f_sRead), .s_write(f_sWrite), .s_writeData(f_sWriteData),
        .s_beginBurstTransfer(f_sBegin), .s_burstCount(f_sBurst),
        .s_readData(s_readData), .s_readDataValid(s_readDataValid),
        .s_waitRequest(s_waitRequest)
    );

    typedef struct {
        logic        m0R, m0W;
        logic [7:0]  m0Bc;
        logic        m1R, m1W;
        logic [7:0]  m1Bc;
        logic        sWait, sRdv;
        logic        eRead, eWrite;
        logic [31:0] eAddr;
        logic        e0Wait, e1Wait, e0Rdv, e1Rdv;
    } vecT;

    vecT vecs[18];

    function automatic vecT mk(
        input logic m0R, input logic m0W, input logic [7:0] m0Bc,
        input logic m1R, input logic m1W, input logic [7:0] m1Bc,
        input logic sWait, input logic sRdv,
        input logic eRead, input logic eWrite, input logic [31:0] eAddr,
        input logic e0Wait, input logic e1Wait,
        input logic e0Rdv, input logic e1Rdv);
        vecT v;
        v.m0R = m0R; v.m0W = m0W; v.m0Bc = m0Bc;
        v.m1R = m1R; v.m1W = m1W; v.m1Bc = m1Bc;
        v.sWait = sWait; v.sRdv = sRdv;
        v.eRead = eRead; v.eWrite = eWrite; v.eAddr = eAddr;
        v.e0Wait = e0Wait; v.e1Wait = e1Wait;
        v.e0Rdv = e0Rdv; v.e1Rdv = e1Rdv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, " sRead"}, 32'(s_read), 32'd0);
        check({tag, " sWrite"}, 32'(s_write), 32'd0);
        check({tag, " sAddr"}, s_address, 32'd0);
        check({tag, " sBurst"}, 32'(s_burstCount), 32'd0);
        check({tag, " m0Wait"}, 32'(m0_waitRequest), 32'd1);
        check({tag, " m1Wait"}, 32'(m1_waitRequest), 32'd1);
        check({tag, " m0Rdv"}, 32'(m0_readDataValid), 32'd0);
        check({tag, " m1Rdv"}, 32'(m1_readDataValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdData[4];
        logic [31:0] got[8];
        int beats, drops, cyc;
        logic m0Held;

        vecs[0]  = mk(0,1,2, 0,1,2, 0,0, 0,0,32'd0, 1,1,0,0);
        vecs[1]  = mk(0,1,2, 0,1,2, 0,0, 0,1,A0,    0,1,0,0);
        vecs[2]  = mk(0,1,2, 0,1,2, 0,0, 0,1,A0,    0,1,0,0);
        vecs[3]  = mk(0,1,2, 0,1,2, 0,0, 0,0,32'd0, 1,1,0,0);
        vecs[4]  = mk(0,1,2, 0,1,2, 0,0, 0,1,A1,    1,0,0,0);
        vecs[5]  = mk(0,1,2, 0,1,2, 0,0, 0,1,A1,    1,0,0,0);
        vecs[6]  = mk(0,1,2, 0,1,2, 0,0, 0,0,32'd0, 1,1,0,0);
        vecs[7]  = mk(0,1,2, 0,1,2, 1,0, 0,1,A0,    1,1,0,0);
        vecs[8]  = mk(0,1,2, 0,1,2, 0,1, 0,1,A0,    0,1,0,0);
        vecs[9]  = mk(0,1,2, 0,1,2, 0,0, 0,1,A0,    0,1,0,0);
        vecs[10] = mk(1,0,1, 0,0,0, 0,0, 0,0,32'd0, 1,1,0,0);
        vecs[11] = mk(1,0,1, 0,0,0, 0,1, 1,0,A0,    0,1,0,0);
        vecs[12] = mk(0,0,0, 0,0,0, 0,0, 0,0,32'd0, 1,1,0,0);
        vecs[13] = mk(0,0,0, 0,0,0, 0,1, 0,0,32'd0, 1,1,1,0);
        vecs[14] = mk(1,0,0, 0,0,0, 0,1, 0,0,32'd0, 1,1,0,0);
        vecs[15] = mk(1,0,0, 0,0,0, 0,0, 1,0,A0,    0,1,0,0);
        vecs[16] = mk(0,0,0, 0,0,0, 0,1, 0,0,32'd0, 1,1,1,0);
        vecs[17] = mk(0,0,0, 0,0,0, 0,0, 0,0,32'd0, 1,1,0,0);

        rdData[0] = 32'hD000_0000; rdData[1] = 32'hD111_1111;
        rdData[2] = 32'hD222_2222; rdData[3] = 32'hD333_3333;

        rst_n = 1'b0;
        m0_address = A0; m1_address = A1;
        m0_byteEnable = 4'hF; m1_byteEnable = 4'hF;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_writeData = 32'hA0A0_0000; m1_writeData = 32'hB0B0_0000;
        m0_beginBurstTransfer = 0; m1_beginBurstTransfer = 0;
        m0_burstCount = 0; m1_burstCount = 0;
        s_readData = 0; s_readDataValid = 0; s_waitRequest = 0;
        #3;
        checkIdle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            m0_read = vecs[i].m0R; m0_write = vecs[i].m0W;
            m0_burstCount = vecs[i].m0Bc;
            m1_read = vecs[i].m1R; m1_write = vecs[i].m1W;
            m1_burstCount = vecs[i].m1Bc;
            s_waitRequest = vecs[i].sWait;
            s_readDataValid = vecs[i].sRdv;
            #1;
            check($sformatf("v%0d sRead", i), 32'(s_read), 32'(vecs[i].eRead));
            check($sformatf("v%0d sWrite", i), 32'(s_write), 32'(vecs[i].eWrite));
            check($sformatf("v%0d sAddr", i), s_address, vecs[i].eAddr);
            check($sformatf("v%0d m0Wait", i), 32'(m0_waitRequest),
                  32'(vecs[i].e0Wait));
            check($sformatf("v%0d m1Wait", i), 32'(m1_waitRequest),
                  32'(vecs[i].e1Wait));
            check($sformatf("v%0d m0Rdv", i), 32'(m0_readDataValid),
                  32'(vecs[i].e0Rdv));
            check($sformatf("v%0d m1Rdv", i), 32'(m1_readDataValid),
                  32'(vecs[i].e1Rdv));
        end

        // m0 read burst of 4, data returned two cycles after acceptance
        @(negedge clk);
        m0_read = 1; m0_burstCount = 8'd4; s_waitRequest = 0;
        #1 check("rd4 idleWait", 32'(m0_waitRequest), 32'd1);
        @(negedge clk);
        #1 check("rd4 sRead", 32'(s_read), 32'd1);
        check("rd4 sBurst", 32'(s_burstCount), 32'd4);
        @(negedge clk);
        m0_read = 0;
        #1 check("rd4 gap0", 32'(m0_readDataValid), 32'd0);
        @(negedge clk);
        #1 check("rd4 gap1", 32'(m0_readDataValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_readDataValid = 1; s_readData = rdData[i];
            #1;
            check($sformatf("rd4 v%0d", i), 32'(m0_readDataValid), 32'd1);
            check($sformatf("rd4 d%0d", i), m0_readData, rdData[i]);
            check($sformatf("rd4 m1v%0d", i), 32'(m1_readDataValid), 32'd0);
        end
        @(negedge clk);
        s_readDataValid = 0;
        m1_write = 1; m1_burstCount = 8'd1; m1_writeData = 32'hC0DE_0001;
        #1 check("rd4 release", 32'(s_read), 32'd0);
        @(negedge clk);
        #1 check("rd4 nextW", 32'(s_write), 32'd1);
        check("rd4 nextA", s_address, A1);
        check("rd4 nextD", s_writeData, 32'hC0DE_0001);
        @(negedge clk);
        m1_write = 0;

        // m1 burst of 8 with stalls and idle beats, m0 read held pending
        m1_write = 1; m1_burstCount = 8'd8; m1_writeData = 32'hB000_0000;
        @(negedge clk);
        m0_read = 1; m0_burstCount = 8'd1;
        beats = 0; drops = 0; cyc = 0; m0Held = 1'b1;
        while (beats < 8 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            s_waitRequest = cyc[0];
            if (beats == 4 && drops < 2) begin
                m1_write = 0;
                drops++;
            end else begin
                m1_write = 1;
            end
            m1_writeData = 32'hB000_0000 + 32'(beats);
            #1;
            if (m0_waitRequest !== 1'b1) m0Held = 1'b0;
            if (s_write && !s_waitRequest) begin
                got[beats] = s_writeData;
                beats++;
            end
            cyc++;
        end
        check("wr8 beats", 32'(beats), 32'd8);
        check("wr8 drops", 32'(drops), 32'd2);
        check("wr8 m0Held", 32'(m0Held), 32'd1);
        for (int i = 0; i < 8; i++)
            check($sformatf("wr8 d%0d", i), got[i], 32'hB000_0000 + 32'(i));
        @(negedge clk);
        m1_write = 0; s_waitRequest = 0;
        #1 check("wr8 idleW", 32'(s_write), 32'd0);
        check("wr8 idleWait", 32'(m0_waitRequest), 32'd1);
        @(negedge clk);
        #1 check("wr8 m0Read", 32'(s_read), 32'd1);
        check("wr8 m0Addr", s_address, A0);
        @(negedge clk);
        m0_read = 0;
        @(negedge clk);
        s_readDataValid = 1; s_readData = 32'h1234_5678;
        #1 check("wr8 m0Rdv", 32'(m0_readDataValid), 32'd1);
        @(negedge clk);
        s_readDataValid = 0;

        // reset in the middle of a read burst
        m0_read = 1; m0_burstCount = 8'd4;
        @(negedge clk);
        @(negedge clk);
        m0_read = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_readDataValid = 1; s_readData = rdData[i];
            #1 check($sformatf("rst v%0d", i), 32'(m0_readDataValid), 32'd1);
        end
        @(negedge clk);
        rst_n = 0;
        #1 checkIdle("rstMid");
        check("rstMid fWait", 32'(f_m0Wait), 32'd1);
        @(negedge clk);
        s_readDataValid = 0; rst_n = 1;
        @(negedge clk);
        m1_write = 1; m1_burstCount = 8'd1; m1_writeData = 32'hC0DE_0002;
        #1 check("rst idle", 32'(s_write), 32'd0);
        @(negedge clk);
        #1 check("rst m1W", 32'(s_write), 32'd1);
        check("rst m1A", s_address, A1);
        check("rst m1Wait", 32'(m1_waitRequest), 32'd0);
        @(negedge clk);
        m1_write = 0;
        #1 check("rst done", 32'(s_write), 32'd0);

        // contention: round robin alternates, fixed priority keeps m0
        m0_write = 1; m0_burstCount = 8'd1;
        m1_write = 1; m1_burstCount = 8'd1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k % 2 == 1) begin
                check($sformatf("rr k%0d", k), s_address,
                      (((k >> 1) & 1) == 1) ? A1 : A0);
                check($sformatf("fix k%0d", k), f_sAddress, A0);
                check($sformatf("fixW k%0d", k), 32'(f_sWrite), 32'd1);
            end else begin
                check($sformatf("gap k%0d", k), 32'(s_write), 32'd0);
            end
        end
        @(negedge clk);
        m0_write = 0; m1_write = 0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared Avalon-MM bus, carrying address, byteEnable, read, write, writeData, beginBurstTransfer and burstCount.
- Lets the instruction cache (m0) and data cache (m1) share the single external memory port.
- Grants whole bursts atomically. Ownership is held until every write beat is accepted or every read beat is returned.
- Sits between the cache refill/writeback engines and the memory controller.

Parameters:
ROUND_ROBIN, 1, 1 = alternate priority on contention; 0 = fixed priority, m0 always wins.
DATA_W, 32, data width (byteEnable width = DATA_W/8).
ADDR_W, 32, address width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mX_address (X=0,1)  in  ADDR_W  master X address
mX_byteEnable  in  DATA_W/8  master X byte enables
mX_read  in  1  master X read request
mX_write  in  1  master X write request
mX_writeData  in  DATA_W  master X write data
mX_beginBurstTransfer  in  1  master X burst-start marker
mX_burstCount  in  8  master X burst length
mX_readData  out  DATA_W  read data, broadcast copy of s_readData
mX_readDataValid  out  1  read data valid to master X
mX_waitRequest  out  1  stall to master X
s_address  out  ADDR_W  to slave
s_byteEnable  out  DATA_W/8  to slave
s_read  out  1  to slave
s_write  out  1  to slave
s_writeData  out  DATA_W  to slave
s_beginBurstTransfer  out  1  to slave
s_burstCount  out  8  to slave
s_readData  in  DATA_W  from slave
s_readDataValid  in  1  from slave
s_waitRequest  in  1  from slave

Behaviour:
- Clock and reset: one clock domain; rst_n is asynchronous, active-low.
- Reset state:
  - state=IDLE, grant=none, last_grant=1 (so m0 wins the first contention), beat counter=0.
  - All s_ control outputs 0; both mX_waitRequest=1; both mX_readDataValid=0.
- Request definition: req[X] = mX_read | mX_write.
- States: IDLE, WRITE, READ_CMD, READ_DATA.
- IDLE:
  - Slave side is quiet (s_read=s_write=0); both mX_waitRequest=1.
  - Request selection:
    - If exactly one req is high, that master wins.
    - If both are high: with ROUND_ROBIN=1 the master ≠ last_grant wins; with ROUND_ROBIN=0, m0 wins.
  - Grant is registered on the next edge. This costs one cycle of arbitration latency.
  - Winner with write=1: latch burstCount into the counter and go to WRITE. Write has precedence if read and write are both high.
  - Winner with read only: go to READ_CMD.
  - burstCount=0 is treated as 1.
- While granted (WRITE and READ_CMD):
  - All s_ request outputs are combinationally muxed from the granted master.
  - mG_waitRequest = s_waitRequest. The non-granted master sees waitRequest=1.
- WRITE:
  - Each cycle with s_write & !s_waitRequest decrements the counter.
  - The granted master may drop write mid-burst (idle beats); no decrement occurs on those cycles.
  - When the beat that takes the counter 1→0 is accepted: next state IDLE, last_grant=grant.
- READ_CMD:
  - When s_read & !s_waitRequest: latch burstCount (0→1) into the counter and go to READ_DATA.
- READ_DATA:
  - s_read=s_write=0; both mX_waitRequest=1.
  - Each s_readDataValid drives mG_readDataValid=1 and decrements the counter.
  - On the last beat: next state IDLE, last_grant=grant.
- Read data routing:
  - mX_readData = s_readData for both masters, always.
  - mX_readDataValid is asserted only to the granted master, and only in READ_DATA.
  - s_readDataValid outside READ_DATA is dropped.
- No pre-emption. The other master's request is held pending until the current burst completes. After release there is one idle cycle (IDLE) before the next grant.
- Reset mid-burst: immediate return to the reset state. The in-flight burst is abandoned, and the slave is not notified beyond s_read/s_write dropping.
- Counter: 8-bit, never underflows. Decrements happen only while counter≥1.

Test Plan:
- Single m0 read, burstCount=4, s_waitRequest=0, slave returns 4 valids 2 cycles after acceptance → m0_readDataValid pulses exactly 4 times with data D0..D3; m1_readDataValid stays 0; state back to IDLE after the 4th beat.
- m0 and m1 request writes simultaneously from reset, burstCount=2 each → m0 granted first (2 beats on s_), then m1 after one idle cycle. Repeat contention → m1 wins next (round robin); with ROUND_ROBIN=0 → m0 wins every time.
- m1 write burst of 8 with s_waitRequest toggling every other cycle and m1 dropping write for 2 cycles mid-burst → exactly 8 accepted beats with correct data order; m0 read request held off (m0_waitRequest=1) throughout.
- m0 read with burstCount=0 → treated as 1; a single readDataValid releases the grant.
- rst_n pulled low during READ_DATA after 2 of 4 beats → outputs return to reset values asynchronously; after release, a new m1 request is granted normally.
- Spurious s_readDataValid while in IDLE or WRITE → no mX_readDataValid asserted; counter unchanged.
